matrix_mult_seq: RTL and testbench

//  Parametrised N x N matrix multiplier with start/done handshake and sequential inner-product accumulation.
//  One MAC per output element; the k-loop runs over N cycles.

---
 rtl/matrix_mult_seq.sv | 208 ++++++++++++++++++++
 tb/tb_matrix_mult_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_seq.sv
// -----------------------------------------------------------------------------
// matrix_mult_seq
// Sequential N x N matrix multiplier. All N*N inner products are accumulated
// in parallel, one k term per clock, so a result takes N accumulate cycles
// plus one cycle to fit the accumulators into the output width.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst      synchronous active-low reset
//   i_start    request a multiply; only honoured while o_ready=1
//   i_a_flat   matrix A, element (i,j) at [(i*N+j)*DW +: DW]
//   i_b_flat   matrix B, same packing
//   o_ready    1 while idle; a start is accepted this cycle
//   o_busy     1 while accumulating or fitting the result
//   o_done     one-cycle pulse; o_c_flat / o_ovf valid from this cycle
//   o_c_flat   C = A x B, element (i,j) at [(i*N+j)*OW +: OW]
//   o_ovf      1 if any element of the last result left the OW range
//
// state    | meaning
// S_IDLE   | waiting for start, ready=1
// S_MAC    | accumulating term k for every element, k = 0..N-1
// S_FINISH | fitting accumulators into OW bits, publishing result
// -----------------------------------------------------------------------------
module matrix_mult_seq #(
    parameter int N        = 4,
    parameter int DW       = 16,
    parameter int OW       = 32,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [N*N*DW-1:0] i_a_flat,
    input  logic [N*N*DW-1:0] i_b_flat,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [N*N*OW-1:0] o_c_flat,
    output logic              o_ovf
);

    localparam int AW = 2*DW + $clog2(N) + 1;
    // Product of two (DW+1)-bit signed values; the extra bit lets unsigned
    // operands share the signed datapath.
    localparam int PW = 2*DW + 2;
    localparam int KW = $clog2(N);
    // Compare width wide enough for both the accumulator and the OW limits.
    localparam int CW = ((AW > OW) ? AW : OW) + 1;

    localparam logic signed [CW-1:0] C_SMAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [CW-1:0] C_SMIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [CW-1:0] C_UMAX = {{(CW-OW){1'b0}}, {OW{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FINISH
    } state_t;

    state_t                r_state;
    logic [N*N*DW-1:0]     r_a;
    logic [N*N*DW-1:0]     r_b;
    logic [KW-1:0]         r_k;
    logic signed [AW-1:0]  r_acc [N][N];
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [N*N*OW-1:0]     r_c;
    logic                  r_ovf;

    logic signed [AW-1:0]  w_prod [N][N];
    logic [OW:0]           w_fit  [N][N];
    logic [N*N*OW-1:0]     w_c;
    logic                  w_ovf;

    function automatic logic signed [DW:0] ext(input logic [DW-1:0] v);
        return (SIGNED != 0) ? {v[DW-1], v} : {1'b0, v};
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] x,
                                                 input logic [DW-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = PW'(ext(x));
        ye = PW'(ext(y));
        return xe * ye;
    endfunction

    // Returns {overflow, fitted value}.
    function automatic logic [OW:0] fit(input logic signed [AW-1:0] v);
        logic signed [CW-1:0] x;
        x = CW'(v);
        if (SIGNED != 0) begin
            if (x > C_SMAX)
                return {1'b1, (SATURATE != 0) ? C_SMAX[OW-1:0] : x[OW-1:0]};
            else if (x < C_SMIN)
                return {1'b1, (SATURATE != 0) ? C_SMIN[OW-1:0] : x[OW-1:0]};
            else
                return {1'b0, x[OW-1:0]};
        end else begin
            if (x > C_UMAX)
                return {1'b1, (SATURATE != 0) ? C_UMAX[OW-1:0] : x[OW-1:0]};
            else
                return {1'b0, x[OW-1:0]};
        end
    endfunction

    // Term k of every inner product: A[i][k] * B[k][j].
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_prod[i][j] = AW'(mul(r_a[(i*N + int'(r_k))*DW +: DW],
                                       r_b[(int'(r_k)*N + j)*DW +: DW]));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_fit[i][j] = fit(r_acc[i][j]);
            end
        end
    end

    always_comb begin
        w_c   = '0;
        w_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_c[(i*N + j)*OW +: OW] = w_fit[i][j][OW-1:0];
                w_ovf = w_ovf | w_fit[i][j][OW];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[i][j] <= '0;
                end
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a_flat;
                        r_b     <= i_b_flat;
                        r_k     <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                r_acc[i][j] <= '0;
                            end
                        end
                    end
                end
                S_MAC: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
                        end
                    end
                    if (r_k == KW'(N-1)) begin
                        r_k     <= '0;
                        r_state <= S_FINISH;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_c     <= w_c;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_c_flat = r_c;
    assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_matrix_mult_seq
// Five instances cover the configurations of interest:
//   dut0: N=2 DW=8  OW=16 signed   saturate
//   dut1: N=2 DW=16 OW=16 signed   saturate   (shares inputs with dut2)
//   dut2: N=2 DW=16 OW=16 signed   wrap
//   dut3: N=4 DW=8  OW=16 unsigned saturate   (shares inputs with dut4)
//   dut4: N=4 DW=8  OW=16 unsigned wrap
// Expected results come from a behavioural integer model and are queued when
// a start is driven; a negedge monitor pops them when done pulses.
// -----------------------------------------------------------------------------
module tb_matrix_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [255:0] c;
        logic         ovf;
        int           t0;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

    logic         rst_n;
    logic         start0, start1, start3;
    logic [31:0]  a0, b0;
    logic [63:0]  a1, b1;
    logic [127:0] a3, b3;
    logic         rdy0, bsy0, dn0, ov0;
    logic         rdy1, bsy1, dn1, ov1;
    logic         rdy2, bsy2, dn2, ov2;
    logic         rdy3, bsy3, dn3, ov3;
    logic         rdy4, bsy4, dn4, ov4;
    logic [63:0]  c0, c1, c2;
    logic [255:0] c3, c4;

    matrix_mult_seq #(.N(2), .DW(8), .OW(16), .SIGNED(1), .SATURATE(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start0), .i_a_flat(a0), .i_b_flat(b0),
        .o_ready(rdy0), .o_busy(bsy0), .o_done(dn0), .o_c_flat(c0), .o_ovf(ov0));
    matrix_mult_seq #(.N(2), .DW(16), .OW(16), .SIGNED(1), .SATURATE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start1), .i_a_flat(a1), .i_b_flat(b1),
        .o_ready(rdy1), .o_busy(bsy1), .o_done(dn1), .o_c_flat(c1), .o_ovf(ov1));
    matrix_mult_seq #(.N(2), .DW(16), .OW(16), .SIGNED(1), .SATURATE(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start1), .i_a_flat(a1), .i_b_flat(b1),
        .o_ready(rdy2), .o_busy(bsy2), .o_done(dn2), .o_c_flat(c2), .o_ovf(ov2));
    matrix_mult_seq #(.N(4), .DW(8), .OW(16), .SIGNED(0), .SATURATE(1)) u_dut3 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start3), .i_a_flat(a3), .i_b_flat(b3),
        .o_ready(rdy3), .o_busy(bsy3), .o_done(dn3), .o_c_flat(c3), .o_ovf(ov3));
    matrix_mult_seq #(.N(4), .DW(8), .OW(16), .SIGNED(0), .SATURATE(0)) u_dut4 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start3), .i_a_flat(a3), .i_b_flat(b3),
        .o_ready(rdy4), .o_busy(bsy4), .o_done(dn4), .o_c_flat(c4), .o_ovf(ov4));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint elem(input logic [255:0] x, input int idx, input int dw,
                                    input int sgn);
        longint v;
        v = longint'(x >> (idx*dw)) & ((longint'(1) << dw) - 1);
        if (sgn != 0 && v[dw-1]) v = v - (longint'(1) << dw);
        return v;
    endfunction

    function automatic void model(input int n, input int dw, input int ow, input int sgn,
                                  input int sat, input logic [255:0] a, input logic [255:0] b,
                                  output logic [255:0] c, output logic ovf);
        longint acc, hi, lo, r, mask;
        c    = '0;
        ovf  = 1'b0;
        mask = (longint'(1) << ow) - 1;
        hi   = (sgn != 0) ? (longint'(1) << (ow-1)) - 1 : mask;
        lo   = (sgn != 0) ? -(longint'(1) << (ow-1)) : 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = 0;
                for (int k = 0; k < n; k++)
                    acc += elem(a, i*n+k, dw, sgn) * elem(b, k*n+j, dw, sgn);
                r = acc;
                if (acc > hi) begin
                    ovf = 1'b1;
                    if (sat != 0) r = hi;
                end else if (acc < lo) begin
                    ovf = 1'b1;
                    if (sat != 0) r = lo;
                end
                c = c | (256'(r & mask) << ((i*n+j)*ow));
            end
        end
    endfunction

    function automatic logic [31:0] p8(input int e00, input int e01, input int e10, input int e11);
        return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
    endfunction

    // Drives one start on dut0 at the current negedge; the next posedge accepts it.
    task automatic issue0(input logic [31:0] a, input logic [31:0] b, input bit keep);
        exp_t e;
        model(2, 8, 16, 1, 1, 256'(a), 256'(b), e.c, e.ovf);
        e.t0 = cyc + 1;
        chk("rdy0_at_start", 256'(rdy0), 256'(1));
        q0.push_back(e);
        a0 = a; b0 = b; start0 = 1'b1;
        @(negedge clk);
        if (!keep) start0 = 1'b0;
    endtask

    task automatic issue1(input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e.t0 = cyc + 1;
        model(2, 16, 16, 1, 1, 256'(a), 256'(b), e.c, e.ovf);
        q1.push_back(e);
        model(2, 16, 16, 1, 0, 256'(a), 256'(b), e.c, e.ovf);
        q2.push_back(e);
        chk("rdy12_at_start", 256'({rdy1, rdy2}), 256'(2'b11));
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic issue3(input logic [127:0] a, input logic [127:0] b);
        exp_t e;
        e.t0 = cyc + 1;
        model(4, 8, 16, 0, 1, 256'(a), 256'(b), e.c, e.ovf);
        q3.push_back(e);
        model(4, 8, 16, 0, 0, 256'(a), 256'(b), e.c, e.ovf);
        q4.push_back(e);
        chk("rdy34_at_start", 256'({rdy3, rdy4}), 256'(2'b11));
        a3 = a; b3 = b; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
    endtask

    function automatic int pending();
        return q0.size() + q1.size() + q2.size() + q3.size() + q4.size();
    endfunction

    task automatic wait_all(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pending() != 0) chk("timeout_pending", 256'(pending()), 256'(0));
    endtask

    task automatic chk_res(input string tag, input exp_t e, input logic [255:0] c,
                           input logic ovf, input int n);
        chk({tag, "_c"}, c, e.c);
        chk({tag, "_ovf"}, 256'(ovf), 256'(e.ovf));
        chk({tag, "_lat"}, 256'(cyc - e.t0), 256'(n + 1));
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dn0 === 1'b1) begin
                if (q0.size() == 0) chk("spurious_done0", 256'(1), 256'(0));
                else begin m_e = q0.pop_front(); chk_res("op0", m_e, 256'(c0), ov0, 2); end
            end
            if (dn1 === 1'b1) begin
                if (q1.size() == 0) chk("spurious_done1", 256'(1), 256'(0));
                else begin m_e = q1.pop_front(); chk_res("op1", m_e, 256'(c1), ov1, 2); end
            end
            if (dn2 === 1'b1) begin
                if (q2.size() == 0) chk("spurious_done2", 256'(1), 256'(0));
                else begin m_e = q2.pop_front(); chk_res("op2", m_e, 256'(c2), ov2, 2); end
            end
            if (dn3 === 1'b1) begin
                if (q3.size() == 0) chk("spurious_done3", 256'(1), 256'(0));
                else begin m_e = q3.pop_front(); chk_res("op3", m_e, c3, ov3, 4); end
            end
            if (dn4 === 1'b1) begin
                if (q4.size() == 0) chk("spurious_done4", 256'(1), 256'(0));
                else begin m_e = q4.pop_front(); chk_res("op4", m_e, c4, ov4, 4); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        logic [31:0] ta, tb;
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);

        // Reset state of every instance
        chk("rst_ready", 256'({rdy0, rdy1, rdy2, rdy3, rdy4}), 256'(5'b11111));
        chk("rst_busy",  256'({bsy0, bsy1, bsy2, bsy3, bsy4}), 256'(0));
        chk("rst_done",  256'({dn0, dn1, dn2, dn3, dn4}), 256'(0));
        chk("rst_ovf",   256'({ov0, ov1, ov2, ov3, ov4}), 256'(0));
        chk("rst_c012",  {64'(0), c0, c1, c2}, 256'(0));
        chk("rst_c34",   c3 | c4, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // T1: basic result and handshake timing
        issue0(p8(1, 2, 3, 4), p8(5, 6, 7, 8), 1'b0);
        chk("t1_busy_c0", 256'({bsy0, rdy0}), 256'(2'b10));
        @(negedge clk);
        chk("t1_busy_c1", 256'({bsy0, rdy0, dn0}), 256'(3'b100));
        @(negedge clk);
        chk("t1_busy_c2", 256'({bsy0, rdy0, dn0}), 256'(3'b100));
        @(negedge clk);
        chk("t1_done_c3", 256'({bsy0, rdy0, dn0}), 256'(3'b011));
        chk("t1_c", 256'(c0), 256'({16'd50, 16'd43, 16'd22, 16'd19}));
        chk("t1_ovf", 256'(ov0), 256'(0));
        @(negedge clk);
        chk("t1_done_1cyc", 256'(dn0), 256'(0));
        wait_all(20);

        // T2: signed operands times identity
        issue0(p8(-1, 2, 3, -4), p8(1, 0, 0, 1), 1'b0);
        wait_all(20);
        chk("t2_c", 256'(c0), 256'({16'hFFFC, 16'd3, 16'd2, 16'hFFFF}));
        chk("t2_ovf", 256'(ov0), 256'(0));

        // T4: start held high while busy with A zeroed, then accepted in the done cycle
        issue0(p8(1, 2, 3, 4), p8(5, 6, 7, 8), 1'b1);
        a0 = '0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("t4_done_cycle", 256'({dn0, rdy0}), 256'(2'b11));
        issue0(p8(2, 0, 0, 2), p8(5, 6, 7, 8), 1'b0);
        wait_all(20);
        chk("t4_second_c", 256'(c0), 256'({16'd16, 16'd14, 16'd12, 16'd10}));

        // T3: signed 16-bit overflow, saturate vs wrap
        issue1({4{16'h7FFF}}, {4{16'h7FFF}});
        wait_all(20);
        chk("t3_sat_c", 256'(c1), 256'({4{16'h7FFF}}));
        chk("t3_wrap_c", 256'(c2), 256'({4{16'h0002}}));
        chk("t3_ovf", 256'({ov1, ov2}), 256'(2'b11));

        // T6: unsigned N=4 overflow, saturate vs wrap
        issue3({16{8'hFF}}, {16{8'hFF}});
        wait_all(40);
        chk("t6_sat_c", c3, {16{16'hFFFF}});
        chk("t6_wrap_c", c4, {16{16'hF804}});
        chk("t6_ovf", 256'({ov3, ov4}), 256'(2'b11));

        // ovf is not sticky: an in-range op clears it
        issue3({16{8'h0F}}, {16{8'h03}});
        wait_all(40);
        chk("t6_ovf_clear", 256'({ov3, ov4}), 256'(0));

        // T5: reset in the middle of MAC aborts the op
        issue0(p8(1, 2, 3, 4), p8(5, 6, 7, 8), 1'b0);
        rst_n = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("t5_c", 256'(c0), 256'(0));
        chk("t5_flags", 256'({ov0, bsy0, rdy0, dn0}), 256'(4'b0010));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue0(p8(1, 2, 3, 4), p8(5, 6, 7, 8), 1'b0);
        wait_all(20);
        chk("t5_fresh_c", 256'(c0), 256'({16'd50, 16'd43, 16'd22, 16'd19}));

        // Random operands on each configuration
        for (int r = 0; r < 8; r++) begin
            ta = $urandom;
            tb = $urandom;
            issue0(ta, tb, 1'b0);
            wait_all(20);
        end
        for (int r = 0; r < 3; r++) begin
            issue1({$urandom, $urandom}, {$urandom, $urandom});
            wait_all(20);
            issue1({$urandom, $urandom} & {4{16'h00FF}}, {$urandom, $urandom} & {4{16'h00FF}});
            wait_all(20);
        end
        for (int r = 0; r < 3; r++) begin
            issue3({$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom});
            wait_all(40);
            issue3({$urandom, $urandom, $urandom, $urandom} & {16{8'h1F}},
                   {$urandom, $urandom, $urandom, $urandom} & {16{8'h1F}});
            wait_all(40);
        end

        repeat (4) @(negedge clk);
        chk("final_pending", 256'(pending()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
